// File: rtl/heart_rate_pkg.sv
// Shared types and constants for the heart-rate monitor: FSM state encoding,
// active-low seven-segment glyphs and default alarm thresholds.
package heart_rate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COUNT,
    ST_CAPTURE,
    ST_DISPLAY
  } hr_state_e;

  localparam int unsigned DEF_LOW_BPM  = 60;
  localparam int unsigned DEF_HIGH_BPM = 100;
  localparam logic [9:0]  BEAT_MAX     = 10'd999;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/hr_display.sv
// Multiplexed 3-digit seven-segment driver: binary-to-BCD conversion of the
// BPM value and a free-running digit scan (units, tens, hundreds).
module hr_display
  import heart_rate_pkg::*;
#(
  parameter int unsigned MUX_DIV = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] bpm_i,
  output logic [2:0] an_o,
  output logic [6:0] seg_o
);

  localparam int unsigned MW       = $clog2(MUX_DIV + 1);
  localparam logic [MW-1:0] MUX_LAST = MW'(MUX_DIV - 1);

  logic [MW-1:0] mux_cnt_q, mux_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [21:0]   dd;
  logic [3:0]    units, tens, hundreds, digit;

  always_comb begin
    mux_cnt_d = mux_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (mux_cnt_q == MUX_LAST) begin
      mux_cnt_d = '0;
      idx_d     = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mux_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      mux_cnt_q <= mux_cnt_d;
      idx_q     <= idx_d;
    end
  end

  // Shift-add-3 conversion; 12 BCD bits sit above the 10 binary bits
  always_comb begin
    dd = {12'b0, bpm_i};
    for (int unsigned i = 0; i < 10; i++) begin
      if (dd[13:10] >= 4'd5) dd[13:10] = dd[13:10] + 4'd3;
      if (dd[17:14] >= 4'd5) dd[17:14] = dd[17:14] + 4'd3;
      if (dd[21:18] >= 4'd5) dd[21:18] = dd[21:18] + 4'd3;
      dd = dd << 1;
    end
    units    = dd[13:10];
    tens     = dd[17:14];
    hundreds = dd[21:18];
  end

  always_comb begin
    an_o  = 3'b110;
    digit = units;
    case (idx_q)
      2'd0: begin an_o = 3'b110; digit = units;    end
      2'd1: begin an_o = 3'b101; digit = tens;     end
      default: begin an_o = 3'b011; digit = hundreds; end
    endcase
    seg_o = seg7(digit);
  end

endmodule

// File: rtl/heart_rate_monitor.sv
// Heart-rate monitor: sequences clear/count/capture, counts internally
// generated beats over a fixed window and displays the captured BPM.
module heart_rate_monitor
  import heart_rate_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 10,
  parameter int unsigned WIN_TICKS = 600,
  parameter int unsigned MUX_DIV   = 64,
  parameter int unsigned LOW_BPM   = DEF_LOW_BPM,
  parameter int unsigned HIGH_BPM  = DEF_HIGH_BPM
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned PW = $clog2(TICK_DIV + 1);
  localparam int unsigned TW = $clog2(WIN_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(WIN_TICKS - 1);
  localparam logic [9:0]    LOW_L      = 10'(LOW_BPM);
  localparam logic [9:0]    HIGH_L     = 10'(HIGH_BPM);

  hr_state_e state_q, state_d;

  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    phase_q, phase_d;
  logic [9:0]    beat_q, beat_d;
  logic [9:0]    bpm_q, bpm_d;

  logic       start, cls;
  logic       clear, en_count, en_cap, alarm;
  logic       tick, win_done, hit;
  logic [8:0] phase_inc;
  logic [2:0] an;
  logic [6:0] seg;
  logic       unused_ok;

  assign start     = uio_in[0];
  assign cls       = uio_in[1];
  assign unused_ok = &{ena, uio_in[7:2]};

  assign tick      = en_count && (presc_q == PRESC_LAST);
  assign win_done  = tick && (tick_cnt_q == TICK_LAST);
  assign phase_inc = {1'b0, phase_q} + 9'd1;
  assign hit       = (ui_in != 8'd0) && (phase_inc == {1'b0, ui_in});

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cls) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (start) state_d = ST_CLEAR;
        ST_CLEAR:   state_d = ST_COUNT;
        ST_COUNT:   if (win_done) state_d = ST_CAPTURE;
        ST_CAPTURE: state_d = ST_DISPLAY;
        ST_DISPLAY: if (start) state_d = ST_CLEAR;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    clear    = 1'b0;
    en_count = 1'b0;
    en_cap   = 1'b0;
    case (state_q)
      ST_CLEAR:   clear    = 1'b1;
      ST_COUNT:   en_count = 1'b1;
      ST_CAPTURE: en_cap   = 1'b1;
      default:    ;
    endcase
  end

  always_comb begin
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    beat_d     = beat_q;
    bpm_d      = bpm_q;
    if (clear) begin
      presc_d    = '0;
      tick_cnt_d = '0;
      phase_d    = '0;
      beat_d     = '0;
    end else if (en_count) begin
      if (tick) begin
        presc_d    = '0;
        tick_cnt_d = tick_cnt_q + 1'b1;
        // set_pulso is read live; a phase already past it wraps at 256
        phase_d    = hit ? 8'd0 : phase_inc[7:0];
        if (hit && beat_q != BEAT_MAX) beat_d = beat_q + 10'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (cls)         bpm_d = '0;
    else if (en_cap) bpm_d = beat_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      tick_cnt_q <= '0;
      phase_q    <= '0;
      beat_q     <= '0;
      bpm_q      <= '0;
    end else begin
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      beat_q     <= beat_d;
      bpm_q      <= bpm_d;
    end
  end

  assign alarm = (state_q == ST_DISPLAY) && ((bpm_q < LOW_L) || (bpm_q > HIGH_L));

  hr_display #(
    .MUX_DIV (MUX_DIV)
  ) u_display (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bpm_i  (bpm_q),
    .an_o   (an),
    .seg_o  (seg)
  );

  assign uo_out  = {alarm, seg};
  assign uio_out = {2'b00, clear, en_cap, en_count, an};
  assign uio_oe  = 8'b0011_1100;

endmodule

// File: tb/tb_heart_rate_monitor.sv
// Self-checking bench for heart_rate_monitor: directed and random beat periods
// compared against an arithmetic reference model of beats per window.
module tb_heart_rate_monitor;

  localparam int unsigned TICK_DIV  = 10;
  localparam int unsigned WIN_TICKS = 600;
  localparam int unsigned MUX_DIV   = 64;
  localparam int unsigned WIN_CYC   = TICK_DIV * WIN_TICKS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  heart_rate_monitor #(
    .TICK_DIV  (TICK_DIV),
    .WIN_TICKS (WIN_TICKS),
    .MUX_DIV   (MUX_DIV),
    .LOW_BPM   (60),
    .HIGH_BPM  (100)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned model_bpm(input int unsigned period);
    int unsigned b;
    b = (period == 0) ? 0 : WIN_TICKS / period;
    return (b > 999) ? 999 : b;
  endfunction

  function automatic int unsigned model_alarm(input int unsigned bpm);
    return ((bpm < 60) || (bpm > 100)) ? 1 : 0;
  endfunction

  // Align to the start of a units slot, then walk all three digits
  task automatic check_display(input int unsigned bpm);
    int unsigned n;
    int unsigned digs [3];
    digs[0] = bpm % 10;
    digs[1] = (bpm / 10) % 10;
    digs[2] = bpm / 100;
    n = 0;
    while (uio_out[2:0] == 3'b110 && n < 4 * MUX_DIV) begin @(negedge clk); n++; end
    n = 0;
    while (uio_out[2:0] != 3'b110 && n < 4 * MUX_DIV) begin @(negedge clk); n++; end
    chk("mux_sync", uio_out[2:0], 3'b110);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: chk("an_units", uio_out[2:0], 3'b110);
        1: chk("an_tens", uio_out[2:0], 3'b101);
        default: chk("an_hundreds", uio_out[2:0], 3'b011);
      endcase
      chk("seg_digit", uo_out[6:0], seg_tab[digs[k]]);
      chk("oe", uio_oe, 8'h3C);
      repeat (MUX_DIV) @(negedge clk);
    end
  endtask

  task automatic run_measure(input int unsigned period);
    int unsigned n;
    int unsigned exp_bpm;
    exp_bpm = model_bpm(period);
    ui_in  = period[7:0];
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    chk("clear_pulse", uio_out[5], 1);
    chk("no_count_in_clear", uio_out[3], 0);
    @(negedge clk);
    n = 0;
    while (uio_out[3] && n < WIN_CYC + 100) begin n++; @(negedge clk); end
    chk("count_len", n, WIN_CYC);
    chk("cap_pulse", uio_out[4], 1);
    @(negedge clk);
    chk("cap_one_cycle", uio_out[4], 0);
    chk("alarm", uo_out[7], model_alarm(exp_bpm));
    check_display(exp_bpm);
    chk("alarm_hold", uo_out[7], model_alarm(exp_bpm));
  endtask

  initial begin
    int unsigned p;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_clear", uio_out[5], 0);
    chk("rst_en_count", uio_out[3], 0);
    chk("rst_en_cap", uio_out[4], 0);
    chk("rst_alarm", uo_out[7], 0);
    chk("rst_an", uio_out[2:0], 3'b110);
    chk("rst_seg", uo_out[6:0], 7'b1000000);
    chk("rst_hi", uio_out[7:6], 0);
    chk("rst_oe", uio_oe, 8'h3C);
    rst_n = 1'b1;
    @(negedge clk);

    run_measure(16);

    uio_in = 8'h02;
    @(negedge clk);
    uio_in = 8'h00;
    chk("cls_alarm", uo_out[7], 0);
    chk("cls_clear", uio_out[5], 0);
    check_display(0);
    chk("cls_idle_alarm", uo_out[7], 0);

    run_measure(8);
    run_measure(5);
    run_measure(0);
    run_measure(1);

    uio_in = 8'h03;
    @(negedge clk);
    uio_in = 8'h00;
    chk("cls_start_clear", uio_out[5], 0);
    chk("cls_start_alarm", uo_out[7], 0);
    @(negedge clk);
    chk("cls_start_idle", uio_out[3], 0);

    for (int r = 0; r < 2; r++) begin
      p = $urandom_range(255, 2);
      run_measure(p);
    end

    ui_in  = 8'd7;
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    repeat (3000) @(negedge clk);
    chk("mid_count", uio_out[3], 1);
    uio_in = 8'h02;
    @(negedge clk);
    uio_in = 8'h00;
    chk("cls_mid_count", uio_out[3], 0);
    check_display(0);
    chk("cls_mid_alarm", uo_out[7], 0);

    run_measure(12);
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    repeat (2000) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstm_en_count", uio_out[3], 0);
    chk("rstm_an", uio_out[2:0], 3'b110);
    chk("rstm_seg", uo_out[6:0], 7'b1000000);
    chk("rstm_alarm", uo_out[7], 0);
    rst_n = 1'b1;
    @(negedge clk);
    p = $urandom_range(255, 2);
    run_measure(p);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
